// File: rtl/dt_walk_sched.sv
// dt_walk_sched
//   Round-robin scheduler that shares one decision-tree walk engine among
//   NREQ requesters. It owns the node table, loaded through the cfg_* write
//   port. It grants one requester at a time. It walks the tree one node per
//   cycle and fetches the granted requester's feature at each depth. It
//   returns the leaf value, tagged with the requester id, on a valid/ready
//   response port.
//
//   Optional feature: define DT_WALK_SCHED_DEPTH_LIMIT_EN to add the
//   MAX_DEPTH parameter and the rsp_err_o output. A walk then stops with an
//   error when it reaches MAX_DEPTH on a decision node, or when it follows a
//   null (0) child pointer.
//
//   Node word layout, MSB first: {dec, data, next_t, next_f, y}.
//
//   Response handshake: rsp_valid_o rises when a walk finishes. It then stays
//   high, and rsp_id_o / rsp_y_o (and rsp_err_o) stay frozen, until a cycle
//   in which rsp_ready_i is also high. That cycle is the transfer, and
//   rsp_valid_o is low again on the following cycle. The producer never
//   withdraws a response, and rsp_ready_i may be high at any time.
module dt_walk_sched #(
    parameter int NREQ   = 4,
    parameter int DATA   = 8,
    parameter int STATE  = 8,
    parameter int ROOT   = 1,
    parameter int IDW    = $clog2(NREQ),
    parameter int NODE_W = 1 + DATA + STATE + STATE + DATA
`ifdef DT_WALK_SCHED_DEPTH_LIMIT_EN
    ,
    parameter int MAX_DEPTH = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic [IDW-1:0]    feat_id_o,
    output logic [STATE-1:0]  feat_idx_o,
    input  logic [DATA-1:0]   feat_data_i,
    output logic              rsp_valid_o,
    output logic [IDW-1:0]    rsp_id_o,
    output logic [DATA-1:0]   rsp_y_o,
`ifdef DT_WALK_SCHED_DEPTH_LIMIT_EN
    output logic              rsp_err_o,
`endif
    input  logic              rsp_ready_i,
    input  logic              cfg_we_i,
    input  logic [STATE-1:0]  cfg_addr_i,
    input  logic [NODE_W-1:0] cfg_wdata_i,
    output logic              cfg_busy_o,
    output logic              busy_o,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WALK = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state, state_nx;

    // Node table. It is never reset, so its contents survive a reset.
    logic [NODE_W-1:0] node_mem [0:(2**STATE)-1];

    // Walk context.
    logic [IDW-1:0]   cur_id;
    logic [STATE-1:0] ptr;
    logic [STATE-1:0] depth;
    logic [IDW-1:0]   rr_ptr;

    // Decoded view of the current node.
    logic [NODE_W-1:0] node_w;
    logic              node_dec;
    logic [DATA-1:0]   node_data;
    logic [STATE-1:0]  node_nt;
    logic [STATE-1:0]  node_nf;
    logic [DATA-1:0]   node_y;
    logic [STATE-1:0]  next_ptr;

    // Arbiter signals.
    logic [2*NREQ-1:0] req_dbl;
    logic              arb_hit;
    logic [IDW-1:0]    arb_idx;
    int                arb_sum;

    // FSM control strobes.
    logic [NREQ-1:0] gnt_c;
    logic            wr_req;
    logic            take;
    logic            fin_leaf;
    logic            fin_term;
    logic            tbl_we;

    assign node_w = node_mem[ptr];
    assign {node_dec, node_data, node_nt, node_nf, node_y} = node_w;

    // The comparison is unsigned and strict: an equal feature takes the
    // false branch.
    assign next_ptr = (feat_data_i > node_data) ? node_nt : node_nf;

    // Rotate the request vector so that bit 0 is the requester at rr_ptr.
    assign req_dbl = {req_i, req_i} >> rr_ptr;

    // Round-robin pick: first set request at or after rr_ptr, with
    // wrap-around.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        arb_sum = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (!arb_hit && req_dbl[i]) begin
                arb_hit = 1'b1;
                arb_sum = int'(rr_ptr) + i;
                if (arb_sum >= NREQ) begin
                    arb_sum = arb_sum - NREQ;
                end
                arb_idx = IDW'(arb_sum);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next state and per-cycle control. A configuration write wins over
    // a grant in IDLE.
    always_comb begin
        state_nx = state;
        gnt_c    = '0;
        wr_req   = 1'b0;
        take     = 1'b0;
        fin_leaf = 1'b0;
        fin_term = 1'b0;
        case (state)
            S_IDLE: begin
                if (cfg_we_i) begin
                    wr_req = 1'b1;
                end else if (arb_hit) begin
                    take           = 1'b1;
                    gnt_c[arb_idx] = 1'b1;
                    state_nx       = S_WALK;
                end
            end
            S_WALK: begin
                if (node_dec) begin
                    fin_leaf = 1'b1;
                    state_nx = S_RESP;
                end
`ifdef DT_WALK_SCHED_DEPTH_LIMIT_EN
                else if (depth == STATE'(MAX_DEPTH)) begin
                    fin_term = 1'b1;
                    state_nx = S_RESP;
                end
`endif
                else if (next_ptr == '0) begin
                    fin_term = 1'b1;
                    state_nx = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Writes are dropped while reset is held and at the reserved address 0.
    assign tbl_we = wr_req && reset && (cfg_addr_i != '0);

    // Node table write port.
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            node_mem[cfg_addr_i] <= cfg_wdata_i;
        end
    end

    // Walk datapath: latch on grant, step per decision node, capture the
    // result, advance the round-robin pointer on the response transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_id   <= '0;
            ptr      <= STATE'(ROOT);
            depth    <= '0;
            rr_ptr   <= '0;
            rsp_id_o <= '0;
            rsp_y_o  <= '0;
`ifdef DT_WALK_SCHED_DEPTH_LIMIT_EN
            rsp_err_o <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (take) begin
                        cur_id <= arb_idx;
                        ptr    <= STATE'(ROOT);
                        depth  <= STATE'(1);
                    end
                end
                S_WALK: begin
                    if (fin_leaf) begin
                        rsp_y_o  <= node_y;
                        rsp_id_o <= cur_id;
`ifdef DT_WALK_SCHED_DEPTH_LIMIT_EN
                        rsp_err_o <= 1'b0;
`endif
                    end else if (fin_term) begin
                        rsp_y_o  <= '0;
                        rsp_id_o <= cur_id;
`ifdef DT_WALK_SCHED_DEPTH_LIMIT_EN
                        rsp_err_o <= 1'b1;
`endif
                    end else begin
                        ptr   <= next_ptr;
                        depth <= depth + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rr_ptr <= (cur_id == IDW'(NREQ - 1)) ? '0 : cur_id + 1'b1;
                    end
                end
                default: begin
                    cur_id <= cur_id;
                end
            endcase
        end
    end

    // Gating with reset keeps the combinational grant low while reset is held.
    assign gnt_o       = gnt_c & {NREQ{reset}};
    assign feat_id_o   = cur_id;
    assign feat_idx_o  = depth;
    assign rsp_valid_o = (state == S_RESP);
    assign busy_o      = (state != S_IDLE);
    assign cfg_busy_o  = (state != S_IDLE);
    assign dbg_state_o = state;

endmodule

// File: doc/dt_walk_sched.md
Name: dt_walk_sched

Overview:
- Round-robin scheduler and sequencer that shares one decision-tree walk engine among NREQ requesters.
- Owns the node table, which is loaded through a configuration write port.
- Grants one requester at a time and walks the tree one node per cycle, fetching that requester's feature at each depth.
- Returns the leaf value tagged with the requester id over a valid/ready response port.

Parameters:
NREQ, 4, number of requesters (2..16)
DATA, 8, feature, threshold and result width
STATE, 8, node address width; table has 2**STATE entries, address 0 reserved
ROOT, 1, root node address
IDW, $clog2(NREQ), requester id width (derived)
NODE_W, 1+DATA+STATE+STATE+DATA, node word {dec, data, next_t, next_f, y}, MSB first

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
req_i  input  NREQ  per-requester walk request, level, held until granted
gnt_o  output  NREQ  one-hot, high for exactly the acceptance cycle
feat_id_o  output  IDW  requester whose feature is being read
feat_idx_o  output  STATE  feature index = current depth, 1-based
feat_data_i  input  DATA  feature value; combinational response to feat_id_o/feat_idx_o
rsp_valid_o  output  1  result valid
rsp_id_o  output  IDW  id of the requester that owns the result
rsp_y_o  output  DATA  leaf value
rsp_ready_i  input  1  result accepted when high with rsp_valid_o
cfg_we_i  input  1  node table write strobe
cfg_addr_i  input  STATE  node address
cfg_wdata_i  input  NODE_W  node word
cfg_busy_o  output  1  high outside IDLE; writes are ignored while high
busy_o  output  1  high in WALK or RESP

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - gnt_o=0, rsp_valid_o=0, rsp_id_o=0, rsp_y_o=0, busy_o=0, cfg_busy_o=0.
  - Round-robin pointer reset so requester 0 has highest priority.
  - Node table is not cleared.
- A reset asserted mid-walk or mid-response aborts the transaction silently; no response is produced for it.
- FSM states: IDLE, WALK, RESP.
- IDLE:
  - If cfg_we_i=1, write node[cfg_addr_i]. The write takes priority; no grant is issued that cycle. Writes to address 0 are dropped.
  - Else if any req_i bit is set, grant the first set bit at or after rr_ptr (wrapping modulo NREQ).
  - On grant: gnt_o bit high this cycle; latch id; ptr=ROOT; depth=1; next state WALK.
- WALK, one node per cycle, with {dec,data,next_t,next_f,y}=node[ptr]:
  - feat_id_o=latched id; feat_idx_o=depth.
  - dec=1 (leaf): register rsp_y_o=y and rsp_id_o=id; go to RESP.
  - dec=0 (decision): ptr <= (feat_data_i > data) ? next_t : next_f. Compare is unsigned and strict. depth <= depth+1.
  - Next ptr of 0: terminate with rsp_y_o=0 and go to RESP.
  - depth wraps modulo 2**STATE; no protection without the optional feature.
- RESP:
  - rsp_valid_o=1; rsp_id_o and rsp_y_o held stable until rsp_ready_i=1.
  - On handshake: rr_ptr=id+1 mod NREQ; next state IDLE; rsp_valid_o falls next cycle.
- Latency:
  - A leaf reached after d decision nodes gives rsp_valid_o high exactly d+2 cycles after the gnt_o cycle.
  - Minimum turnaround from handshake to next gnt_o is 1 cycle.
- Boundary conditions:
  - req_i bits that drop before being granted are simply not served.
  - Requests arriving during WALK or RESP wait; there is no preemption.
  - Only one outstanding transaction at a time.

Optional Feature:
- Macro: DT_WALK_SCHED_DEPTH_LIMIT_EN.
- When defined:
  - Adds parameter MAX_DEPTH (default 16) and output rsp_err_o (1 bit, reset 0, valid with rsp_valid_o).
  - If depth reaches MAX_DEPTH while in a decision node, the walk terminates: rsp_y_o=0, rsp_err_o=1, go to RESP.
  - A next ptr of 0 also sets rsp_err_o=1.
- When undefined: the port and the limit are absent, and walks are unbounded.

Test Plan:
- Common table: node1={0,50,2,3,x}, node2={1,x,x,x,8'hAA}, node3={1,x,x,x,8'h55}.
- Load common table; req_i=0001, requester 0 feature[1]=60 -> gnt_o=0001 at cycle G; rsp_valid_o at G+3; rsp_y_o=AA; rsp_id_o=0.
- Same table, requester 2 feature[1]=50 (equal, so false branch) -> rsp_y_o=55, rsp_id_o=2.
- req_i=1111 held, rsp_ready_i=1 -> grant order 0,1,2,3,0; each gnt_o one-hot and one cycle wide.
- rsp_ready_i=0 for 5 cycles in RESP -> rsp_valid_o and rsp_y_o stable throughout; no new gnt_o until the handshake.
- cfg_we_i pulsed during WALK targeting node2 -> ignored and cfg_busy_o=1; the same write in IDLE together with req_i=0001 -> write takes effect, grant deferred one cycle.
- reset low mid-WALK -> all outputs 0 immediately; re-request returns correct result (table intact).
- With macro, MAX_DEPTH=4, table looping node1->node1 -> rsp_err_o=1, rsp_y_o=0.
